centroid_feeder: RTL and testbench

//  Drives the pixel-stream side of center_of_mass. Watches a raster-ordered mask stream,

---
 rtl/centroid_feeder.sv | 172 +++++++++++++++++
 tb/tb_centroid_feeder.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/centroid_feeder.sv
// centroid_feeder: turns a raster-ordered mask stream into (x,y,valid) strobes for
// center_of_mass and holds tabulate until its result or a timeout. Define ROI_EN to gate emission to a rectangle.
module centroid_feeder #(
  parameter int H_ACTIVE       = 1280,
  parameter int V_ACTIVE       = 720,
  parameter int MIN_PIXELS     = 1,
  parameter int TIMEOUT_CYCLES = 256
`ifdef ROI_EN
  ,
  parameter int ROI_X0         = 0,
  parameter int ROI_Y0         = 0,
  parameter int ROI_X1         = 1279,
  parameter int ROI_Y1         = 719
`endif
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        mask_in,
  input  logic        pixel_valid_in,
  input  logic        com_valid_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        valid_out,
  output logic        tabulate_out,
  output logic [20:0] pixel_count_out,
  output logic        done_out,
  output logic        skip_out,
  output logic        timeout_out
);

  localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [10:0]   LAST_X     = 11'(H_ACTIVE - 1);
  localparam logic [9:0]    LAST_Y     = 10'(V_ACTIVE - 1);
  localparam logic [20:0]   MIN_CNT    = 21'(MIN_PIXELS);
  localparam logic [20:0]   CNT_MAX    = {21{1'b1}};
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2,
    WAIT    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [10:0]   x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic          valid_q, valid_d;
  logic          tab_q, tab_d;
  logic [20:0]   count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          done_q, done_d;
  logic          skip_q, skip_d;
  logic          timeout_q, timeout_d;

  logic          at_origin, at_last, in_roi, accept, hit;
  logic [20:0]   base_count;

  // A (0,0) pixel always starts a fresh count, whether from IDLE or as a resync mid-frame.
  always_comb begin
    at_origin = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    at_last   = (hcount_in == LAST_X) && (vcount_in == LAST_Y);
`ifdef ROI_EN
    in_roi    = (hcount_in >= 11'(ROI_X0)) && (hcount_in <= 11'(ROI_X1)) &&
                (vcount_in >= 10'(ROI_Y0)) && (vcount_in <= 10'(ROI_Y1));
`else
    in_roi    = 1'b1;
`endif
    accept     = pixel_valid_in &&
                 ((state_q == COLLECT) || ((state_q == IDLE) && at_origin));
    hit        = accept && mask_in && in_roi;
    base_count = at_origin ? 21'd0 : count_q;
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    valid_d   = 1'b0;
    tab_d     = tab_q;
    count_d   = count_q;
    timer_d   = timer_q;
    done_d    = 1'b0;
    skip_d    = 1'b0;
    timeout_d = 1'b0;

    if (hit) begin
      valid_d = 1'b1;
      x_d     = hcount_in;
      y_d     = vcount_in;
    end else begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE, COLLECT: begin
        if (accept) begin
          count_d = (hit && (base_count != CNT_MAX)) ? base_count + 21'd1 : base_count;
          state_d = ((state_q == COLLECT) && at_last) ? FLUSH : COLLECT;
        end else begin
          state_d = state_q;
        end
      end
      // Extra cycle lets the final valid_out land before tabulate rises.
      FLUSH: begin
        timer_d = '0;
        if (count_q >= MIN_CNT) begin
          tab_d   = 1'b1;
          state_d = WAIT;
        end else begin
          skip_d  = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (com_valid_in) begin
          tab_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (timer_q == TIMER_LAST) begin
          tab_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        tab_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      x_q       <= 11'd0;
      y_q       <= 10'd0;
      valid_q   <= 1'b0;
      tab_q     <= 1'b0;
      count_q   <= 21'd0;
      timer_q   <= '0;
      done_q    <= 1'b0;
      skip_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      tab_q     <= tab_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      done_q    <= done_d;
      skip_q    <= skip_d;
      timeout_q <= timeout_d;
    end
  end

  assign x_out           = x_q;
  assign y_out           = y_q;
  assign valid_out       = valid_q;
  assign tabulate_out    = tab_q;
  assign pixel_count_out = count_q;
  assign done_out        = done_q;
  assign skip_out        = skip_q;
  assign timeout_out     = timeout_q;

endmodule

// File: tb/tb_centroid_feeder.sv
// Scoreboard bench for centroid_feeder: sparse randomized frames, expected strobes and
// events queued at stimulus time, popped and compared by an independent monitor.
module tb_centroid_feeder;

  localparam int T = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        mask, pv, com;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        valid_out, tabulate_out, done_out, skip_out, timeout_out;
  logic [20:0] pixel_count_out;

  always #5 clk = ~clk;

  centroid_feeder #(
    .H_ACTIVE(1280), .V_ACTIVE(720), .MIN_PIXELS(1), .TIMEOUT_CYCLES(T)
`ifdef ROI_EN
    , .ROI_X0(100), .ROI_Y0(100), .ROI_X1(199), .ROI_Y1(199)
`endif
  ) dut (
    .clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
    .mask_in(mask), .pixel_valid_in(pv), .com_valid_in(com),
    .x_out(x_out), .y_out(y_out), .valid_out(valid_out), .tabulate_out(tabulate_out),
    .pixel_count_out(pixel_count_out), .done_out(done_out), .skip_out(skip_out),
    .timeout_out(timeout_out)
  );

  typedef struct { int x; int y; int cyc; } pix_t;
  typedef enum int { EV_TAB = 0, EV_DONE = 1, EV_SKIP = 2, EV_TIMEOUT = 3 } ev_kind_t;
  typedef struct { ev_kind_t kind; int cyc; int cnt; } ev_t;

  pix_t pq[$];
  ev_t  evq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_last_x = 0;
  int   exp_last_y = 0;
  logic tab_prev = 1'b0;
  pix_t mon_p;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit in_roi(int x, int y);
`ifdef ROI_EN
    return (x >= 100) && (x <= 199) && (y >= 100) && (y <= 199);
`else
    return (x >= 0) && (y >= 0);
`endif
  endfunction

  task automatic mon_event(ev_kind_t kind);
    ev_t e;
    if (evq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", kind, cyc);
    end else begin
      e = evq.pop_front();
      chk("event_kind", int'(kind), int'(e.kind));
      chk("event_cycle", cyc, e.cyc);
      chk("event_count", int'(pixel_count_out), e.cnt);
      if (kind != EV_TAB) chk("event_tab_low", int'(tabulate_out), 0);
    end
  endtask

  // Monitor: consumes expected strobes/events whenever the DUT presents them.
  always @(negedge clk) begin
    if (rst) begin
      exp_last_x = 0;
      exp_last_y = 0;
      tab_prev   = 1'b0;
    end else begin
      if (valid_out) begin
        if (pq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: x %0d y %0d at cycle %0d, none expected", x_out, y_out, cyc);
        end else begin
          mon_p = pq.pop_front();
          chk("pix_x", int'(x_out), mon_p.x);
          chk("pix_y", int'(y_out), mon_p.y);
          chk("pix_cycle", cyc, mon_p.cyc);
          exp_last_x = mon_p.x;
          exp_last_y = mon_p.y;
        end
      end else begin
        chk("x_hold", int'(x_out), exp_last_x);
        chk("y_hold", int'(y_out), exp_last_y);
      end
      if (tabulate_out && !tab_prev) mon_event(EV_TAB);
      if (done_out) mon_event(EV_DONE);
      if (skip_out) mon_event(EV_SKIP);
      if (timeout_out) mon_event(EV_TIMEOUT);
      tab_prev = tabulate_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      tick();
      pv = 1'b0;
      com = 1'b0;
      hcount = 11'($urandom_range(0, 1279));
      vcount = 10'($urandom_range(0, 719));
      mask = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic pulse_com();
    tick();
    pv = 1'b0;
    com = 1'b1;
  endtask

  task automatic pixel(int x, int y, bit m, bit live, inout int count);
    tick();
    pv = 1'b1;
    com = 1'b0;
    hcount = 11'(x);
    vcount = 10'(y);
    mask = m;
    if (live && m && in_roi(x, y)) begin
      pq.push_back('{x: x, y: y, cyc: cyc + 1});
      count++;
    end
  endtask

  task automatic drained(string tag);
    chk({tag, "_pix_q_empty"}, pq.size(), 0);
    chk({tag, "_ev_q_empty"}, evq.size(), 0);
  endtask

  // One sparse frame: origin, n_set marked pixels in raster order, optional mid-frame resync, last pixel.
  task automatic frame(int n_set, bit live, bit resync, output int last_cyc, output int count);
    int y;
    int x;
    int split;
    y = 0;
    count = 0;
    split = resync ? int'($urandom_range(0, n_set)) : -1;
    pixel(0, 0, 1'($urandom_range(0, 1)), live, count);
    for (int i = 0; i <= n_set; i++) begin
      if (i == split) begin
        idle($urandom_range(0, 2));
        count = 0;
        pixel(0, 0, 1'($urandom_range(0, 1)), live, count);
      end
      if (i < n_set) begin
        y = y + int'($urandom_range(1, 30));
        x = $urandom_range(0, 1279);
        idle($urandom_range(0, 2));
        if ($urandom_range(0, 2) == 0) pixel(x, y, 1'b0, live, count);
        pixel(x, y, 1'b1, live, count);
      end
    end
    idle($urandom_range(0, 2));
    pixel(1279, 719, 1'($urandom_range(0, 1)), live, count);
    last_cyc = cyc;
  endtask

  // resp < 0: no result; otherwise com_valid_in arrives resp cycles after WAIT is entered.
  task automatic expect_result(int last_cyc, int count, int resp);
    if (count == 0) begin
      evq.push_back('{kind: EV_SKIP, cyc: last_cyc + 2, cnt: 0});
      idle(4);
    end else begin
      evq.push_back('{kind: EV_TAB, cyc: last_cyc + 2, cnt: count});
      if (resp < 0) begin
        evq.push_back('{kind: EV_TIMEOUT, cyc: last_cyc + 2 + T, cnt: count});
        idle(T + 4);
      end else begin
        if (resp <= T - 1)
          evq.push_back('{kind: EV_DONE, cyc: last_cyc + 3 + resp, cnt: count});
        else
          evq.push_back('{kind: EV_TIMEOUT, cyc: last_cyc + 2 + T, cnt: count});
        idle(1 + resp);
        pulse_com();
        idle(4);
      end
    end
    drained("result");
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    pv = 1'b0;
    com = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_x", int'(x_out), 0);
    chk("rst_y", int'(y_out), 0);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_tab", int'(tabulate_out), 0);
    chk("rst_count", int'(pixel_count_out), 0);
    chk("rst_done", int'(done_out), 0);
    chk("rst_skip", int'(skip_out), 0);
    chk("rst_timeout", int'(timeout_out), 0);
  endtask

  initial begin
    int last;
    int count;
    int r;
    int resp;
    rst = 1'b1; pv = 1'b0; com = 1'b0; hcount = 11'd0; vcount = 10'd0; mask = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("init_valid", int'(valid_out), 0);
    chk("init_tab", int'(tabulate_out), 0);
    chk("init_count", int'(pixel_count_out), 0);
    chk("init_x", int'(x_out), 0);
    chk("init_pulses", int'({done_out, skip_out, timeout_out}), 0);
    idle(3);

    // Three marked pixels, result 40 cycles into WAIT.
    count = 0;
    pixel(0, 0, 1'b0, 1'b1, count);
    pixel(10, 20, 1'b1, 1'b1, count);
    idle(2);
    pixel(30, 40, 1'b1, 1'b1, count);
    pixel(50, 60, 1'b1, 1'b1, count);
    idle(1);
    pixel(1279, 719, 1'b0, 1'b1, count);
    last = cyc;
    expect_result(last, count, 40);

    // Empty frame must skip.
    count = 0;
    pixel(0, 0, 1'b0, 1'b1, count);
    idle(3);
    pixel(1279, 719, 1'b0, 1'b1, count);
    last = cyc;
    expect_result(last, count, 0);

    // No result: timeout; then result on the very last WAIT cycle; then one cycle too late.
    frame(3, 1'b1, 1'b0, last, count);
    expect_result(last, count, -1);
    frame(2, 1'b1, 1'b0, last, count);
    expect_result(last, count, T - 1);
    frame(2, 1'b1, 1'b0, last, count);
    expect_result(last, count, T);

    // A frame starting during WAIT is ignored whole; the following one is collected.
    frame(3, 1'b1, 1'b0, last, count);
    if (count == 0) begin
      expect_result(last, count, 0);
    end else begin
      evq.push_back('{kind: EV_TAB, cyc: last + 2, cnt: count});
      idle(2);
      frame(3, 1'b0, 1'b0, r, resp);
      pulse_com();
      evq.push_back('{kind: EV_DONE, cyc: cyc + 1, cnt: count});
      idle(4);
      drained("wait_frame");
    end
    frame(3, 1'b1, 1'b0, last, count);
    expect_result(last, count, 5);

`ifdef ROI_EN
    count = 0;
    pixel(0, 0, 1'b0, 1'b1, count);
    pixel(50, 50, 1'b1, 1'b1, count);
    pixel(150, 150, 1'b1, 1'b1, count);
    pixel(1279, 719, 1'b0, 1'b1, count);
    last = cyc;
    expect_result(last, count, 10);
`endif

    // Lost sync: mid-frame origin restarts the count.
    frame(5, 1'b1, 1'b1, last, count);
    expect_result(last, count, 12);

    // Reset mid-COLLECT, then a clean frame.
    count = 0;
    pixel(0, 0, 1'b1, 1'b1, count);
    pixel(40, 7, 1'b1, 1'b1, count);
    idle(2);
    do_reset();
    drained("rst_collect");
    frame(3, 1'b1, 1'b0, last, count);
    expect_result(last, count, $urandom_range(0, 100));

    // Reset mid-WAIT.
    frame(2, 1'b1, 1'b0, last, count);
    if (count == 0) begin
      expect_result(last, count, 0);
    end else begin
      evq.push_back('{kind: EV_TAB, cyc: last + 2, cnt: count});
      idle(20);
      do_reset();
      drained("rst_wait");
    end

    for (int f = 0; f < 16; f++) begin
      frame($urandom_range(0, 6), 1'b1, ($urandom_range(0, 4) == 0), last, count);
      r = $urandom_range(0, 9);
      if (r == 0) resp = -1;
      else if (r == 1) resp = T - 1;
      else if (r == 2) resp = T;
      else resp = $urandom_range(0, 120);
      expect_result(last, count, resp);
    end

    drained("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
